// File: rtl/ladybird_serial_bridge_if.sv
// ladybird_serial_bridge_if: serial byte streams and single-beat memory bus seen by the bridge
interface ladybird_serial_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_ready, mem_rdata, mem_rvalid,
    output rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_valid
  );
  modport master (
    output rx_data, rx_valid, tx_ready, mem_ready, mem_rdata, mem_rvalid,
    input  rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_valid
  );
endinterface

// File: rtl/ladybird_serial_bridge.sv
// ladybird_serial_bridge: UART byte commands to single-beat memory bus with byte responses.
// Define LADYBIRD_SERIAL_BRIDGE_TIMEOUT_EN to drop partial commands after TIMEOUT idle cycles.
module ladybird_serial_bridge #(
  parameter logic [31:0] TIMEOUT = 32'd10_000_000
) (
  input  logic clk,
  input  logic anrst,
  input  logic nrst,
  ladybird_serial_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM_REQ, MEM_WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
  logic        we_q, we_d, long_q, long_d;
  logic        rx_fire, tx_fire, idle_hit;
  assign rx_fire = bus.rx_valid & bus.rx_ready;
  assign tx_fire = bus.tx_valid & bus.tx_ready;
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst || !nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      we_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      we_q    <= we_d;
      long_q  <= long_d;
    end
  end
`ifdef LADYBIRD_SERIAL_BRIDGE_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  assign idle_hit = (state_q == ADDR || state_q == DATA) && idle_q == TIMEOUT - 32'd1;
  assign idle_d = ((state_q == ADDR || state_q == DATA) && state_d == state_q && !rx_fire) ? idle_q + 32'd1 : '0;
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst || !nrst) idle_q <= '0;
    else idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign idle_hit = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    we_d    = we_q;
    long_d  = long_q;
    unique case (state_q)
      IDLE: if (rx_fire) begin
        we_d    = bus.rx_data == 8'h77;
        state_d = (bus.rx_data == 8'h77 || bus.rx_data == 8'h72) ? ADDR : RESP;
        resp_d  = (bus.rx_data == 8'h77 || bus.rx_data == 8'h72) ? resp_q : 32'h15;
        long_d  = 1'b0;
      end
      ADDR: if (rx_fire) begin
        addr_d  = {bus.rx_data, addr_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q != 2'd3 ? ADDR : we_q ? DATA : MEM_REQ;
      end
      DATA: if (rx_fire) begin
        wdata_d = {bus.rx_data, wdata_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? MEM_REQ : DATA;
      end
      MEM_REQ: if (bus.mem_ready) begin
        state_d = we_q ? RESP : MEM_WAIT;
        resp_d  = we_q ? 32'h06 : resp_q;
      end
      MEM_WAIT: if (bus.mem_rvalid) begin
        state_d = RESP;
        resp_d  = bus.mem_rdata;
        long_d  = 1'b1;
      end
      RESP: if (tx_fire) begin
        resp_d  = resp_q >> 8;
        cnt_d   = cnt_q + 2'd1;
        state_d = (!long_q || cnt_q == 2'd3) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    state_d = idle_hit ? IDLE : state_d;
    cnt_d   = state_d != state_q ? 2'd0 : cnt_d;
  end
  always_comb begin
    bus.rx_ready  = anrst & nrst & (state_q == IDLE || state_q == ADDR || state_q == DATA);
    bus.tx_valid  = state_q == RESP;
    bus.tx_data   = resp_q[7:0];
    bus.mem_valid = state_q == MEM_REQ;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_we    = we_q;
  end
endmodule

// File: doc/ladybird_serial_bridge.md
# ladybird_serial_bridge

Byte-stream command decoder sitting directly downstream of `ladybird_serial_interface` (1-byte configuration). It consumes received UART bytes, parses read/write commands carrying a 32-bit address and data, issues single-beat transactions on a simple memory bus, and returns the response bytes to the serial interface's transmit input. It is the host-side debug/loader path into the SoC memory map.

## Interface
Parameters:
- `TIMEOUT`, default `32'd10_000_000`: idle cycles between bytes of one command before the partial command is dropped. Used only with the timeout feature; must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `anrst`  in  1  reset, asynchronous, active-low.
- `nrst`  in  1  synchronous reset, active-low, same effect as `anrst`.
- `rx_data`  in  8  byte from the serial interface (`o_data`).
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  byte accepted when `rx_valid & rx_ready`.
- `tx_data`  out  8  response byte to the serial interface (`i_data`).
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  response byte taken when `tx_valid & tx_ready`.
- `mem_addr`  out  32  transaction address.
- `mem_wdata`  out  32  write data.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_valid`  out  1  request valid.
- `mem_ready`  in  1  request accepted when `mem_valid & mem_ready`.
- `mem_rdata`  in  32  read data.
- `mem_rvalid`  in  1  read data valid, one cycle, ≥ 1 cycle after read accept.

## Operation
- Command format, all multi-byte fields little-endian: write = `0x77`, addr[4], data[4]; read = `0x72`, addr[4].
- Responses: write → single byte `0x06`; read → 4 bytes of `mem_rdata`, LSB first; unknown opcode → single byte `0x15`, no bus access.
- FSM states: IDLE → (opcode `0x77`/`0x72`) ADDR → (4th addr byte) DATA for write, MEM_REQ for read; DATA → (4th data byte) MEM_REQ; MEM_REQ → (accept) RESP for write, MEM_WAIT for read; MEM_WAIT → (`mem_rvalid`) RESP; RESP → (last response byte accepted) IDLE. Unknown opcode: IDLE → RESP with `0x15`.
- 2-bit byte counter shared by ADDR, DATA and RESP; cleared on every state entry and wraps 3→0 on leaving the state.
- `rx_ready` = 1 only in IDLE, ADDR, DATA; bytes are back-pressured during MEM_REQ, MEM_WAIT, RESP.
- `mem_addr`, `mem_wdata`, `mem_we` are held stable while `mem_valid` = 1. `mem_valid` is held until accepted. Exactly one transaction is outstanding.
- `mem_rdata` is captured into the response register on `mem_rvalid` in MEM_WAIT; `mem_rvalid` in any other state is ignored.
- `tx_valid` = 1 only in RESP; `tx_data` is held stable until accepted.

## Timing
- Reset (`anrst` low, or `nrst` low at clock edge): state IDLE, counters 0, `rx_ready` 0 during reset then 1, `tx_valid` 0, `tx_data` 0, `mem_valid` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
- Reset mid-transaction returns to IDLE immediately and drops `mem_valid` and `tx_valid`; the partial command is discarded.
- `mem_valid` rises the cycle after the final command byte is accepted; zero-wait `mem_ready` gives a 1-cycle request.
- RESP is entered the cycle after write accept or after `mem_rvalid`; `tx_valid` is asserted in that cycle.
- Unknown opcode: `tx_valid` is asserted the cycle after the opcode is accepted.
- Throughput: one command byte per cycle when `rx_valid` is held high.

## Configuration
- `LADYBIRD_SERIAL_BRIDGE_TIMEOUT_EN` defined: a 32-bit idle counter runs in ADDR and DATA. It is cleared on each accepted byte and on state entry. When it reaches `TIMEOUT-1` the FSM returns to IDLE, with no response and no bus access.
- Not defined: no counter; the bridge waits indefinitely for the remaining command bytes.

## Test plan
- Write: bytes `77 10 00 00 80 EF BE AD DE` → one request, `mem_we`=1, `mem_addr`=`0x80000010`, `mem_wdata`=`0xDEADBEEF`; then tx `06`.
- Read: bytes `72 04 00 00 80`, memory returns `0x12345678` 3 cycles after accept → tx `78 56 34 12` in order.
- Unknown opcode `0x41` → tx `15`, `mem_valid` never asserted, next `77…` command executes normally.
- Back-pressure: `mem_ready` low for 10 cycles and `tx_ready` toggling → request fields stable, `rx_ready` 0 throughout, no byte lost or duplicated.
- Timeout (macro on, `TIMEOUT`=100): `72 04`, gap of 150 cycles, then `72 00 00 00 00` → first command dropped silently; second reads address 0.
- `anrst` pulsed while in MEM_WAIT, then a late `mem_rvalid` → outputs at reset values, late `mem_rvalid` ignored, no tx byte.
